alu_control_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle ALU control decoder. It decodes {funct7, ALU_Op, funct3} into a widened ALU/MDU operation code, covering SRA, SLT/SLTU, branch compares and the RV32M multiply/divide group. For multi-cycle M-extension ops it runs a latency counter and FSM, stalls the single-cycle datapath, and pulses start/done to the MDU. It sits between the main control unit and the ALU/MDU in the execute path.

---
 rtl/alu_control_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_control_mc.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_control_mc.sv
// Multi-cycle ALU/MDU control: decodes {funct7, ALU_Op, funct3} and sequences RV32M ops.
// Optional RV32M decode and MDU sequencing are enabled by defining ALU_CTRL_MEXT_EN.
module alu_control_mc #(
  parameter int unsigned OP_WIDTH    = 5,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [6:0]          funct7_i,
  input  logic [2:0]          ALU_Op_i,
  input  logic [2:0]          funct3_i,
  output logic [OP_WIDTH-1:0] ALU_Operation_o,
  output logic                Illegal_o,
  output logic                Stall_o,
  output logic                Mdu_Start_o,
  output logic                Done_o
);

  localparam int unsigned MAX_LAT   = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_LAT + 1);
  localparam int unsigned CODE_W    = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t OP_ADD  = 5'd0;
  localparam code_t OP_SUB  = 5'd1;
  localparam code_t OP_AND  = 5'd2;
  localparam code_t OP_OR   = 5'd3;
  localparam code_t OP_XOR  = 5'd4;
  localparam code_t OP_LUI  = 5'd5;
  localparam code_t OP_SRL  = 5'd6;
  localparam code_t OP_SLL  = 5'd7;
  localparam code_t OP_SRA  = 5'd8;
  localparam code_t OP_SLT  = 5'd9;
  localparam code_t OP_SLTU = 5'd10;
  localparam code_t OP_MUL  = 5'd11;
  localparam code_t OP_DIV  = 5'd15;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  if (OP_WIDTH < 5) begin : g_chk_op
    $error("OP_WIDTH must be >= 5");
  end
  if (MUL_LATENCY < 1 || DIV_LATENCY < 1) begin : g_chk_lat
    $error("MUL_LATENCY and DIV_LATENCY must be >= 1");
  end

  code_t dec_op;
  logic  dec_ill;

  // Pure combinational instruction decode; illegal encodings force op 0.
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    unique case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == F7_BASE) begin
          unique case (funct3_i)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          if (funct3_i == 3'b000)      dec_op  = OP_SUB;
          else if (funct3_i == 3'b101) dec_op  = OP_SRA;
          else                         dec_ill = 1'b1;
`ifdef ALU_CTRL_MEXT_EN
        end else if (funct7_i == F7_MEXT) begin
          dec_op = OP_MUL + code_t'(funct3_i);
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      3'b001: begin
        unique case (funct3_i)
          3'b000: dec_op = OP_ADD;
          3'b001: begin
            if (funct7_i == F7_BASE) dec_op  = OP_SLL;
            else                     dec_ill = 1'b1;
          end
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b101: begin
            if (funct7_i == F7_BASE)     dec_op  = OP_SRL;
            else if (funct7_i == F7_ALT) dec_op  = OP_SRA;
            else                         dec_ill = 1'b1;
          end
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      3'b010: dec_op = OP_ADD;
      3'b011: begin
        unique case (funct3_i)
          3'b000, 3'b001: dec_op  = OP_SUB;
          3'b100, 3'b101: dec_op  = OP_SLT;
          3'b110, 3'b111: dec_op  = OP_SLTU;
          default:        dec_ill = 1'b1;
        endcase
      end
      3'b100:  dec_op  = OP_LUI;
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_op = OP_ADD;
  end

`ifdef ALU_CTRL_MEXT_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  code_t                op_q, op_d;
  logic                 is_mdu, is_div;

  assign is_mdu = !dec_ill && (dec_op >= OP_MUL);
  assign is_div = dec_op >= OP_DIV;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // In BUSY the latched op is held and the inputs are ignored until the counter expires.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    ALU_Operation_o = OP_WIDTH'(dec_op);
    Illegal_o       = dec_ill;
    Stall_o         = 1'b0;
    Mdu_Start_o     = 1'b0;
    Done_o          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && is_mdu) begin
          Stall_o     = 1'b1;
          Mdu_Start_o = 1'b1;
          state_d     = BUSY;
          op_d        = dec_op;
          cnt_d       = is_div ? CNT_WIDTH'(DIV_LATENCY - 1) : CNT_WIDTH'(MUL_LATENCY - 1);
        end
      end
      BUSY: begin
        ALU_Operation_o = OP_WIDTH'(op_q);
        Illegal_o       = 1'b0;
        if (cnt_q != '0) begin
          Stall_o = 1'b1;
          cnt_d   = CNT_WIDTH'(cnt_q - 1'b1);
        end else begin
          Done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic                 unused_ok;
  logic [CNT_WIDTH-1:0] unused_cnt;

  assign unused_ok       = ^{clk, reset, valid_i, F7_MEXT, OP_DIV};
  assign unused_cnt      = '0;
  assign ALU_Operation_o = OP_WIDTH'(dec_op);
  assign Illegal_o       = dec_ill;
  assign Stall_o         = 1'b0;
  assign Mdu_Start_o     = 1'b0;
  assign Done_o          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_mc.sv
// Scoreboard bench for alu_control_mc; covers both ALU_CTRL_MEXT_EN builds.
module tb_alu_control_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [6:0] funct7_i;
  logic [2:0] ALU_Op_i;
  logic [2:0] funct3_i;
  logic [4:0] ALU_Operation_o;
  logic       Illegal_o, Stall_o, Mdu_Start_o, Done_o;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];

  alu_control_mc #(.OP_WIDTH(5), .MUL_LATENCY(2), .DIV_LATENCY(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct7_i(funct7_i),
    .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .ALU_Operation_o(ALU_Operation_o),
    .Illegal_o(Illegal_o), .Stall_o(Stall_o), .Mdu_Start_o(Mdu_Start_o), .Done_o(Done_o)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus; when chk is set the expected response is queued.
  task automatic cyc(input logic rst, input logic v, input logic [6:0] f7,
                     input logic [2:0] aop, input logic [2:0] f3, input bit chk,
                     input string nm, input logic [4:0] op, input logic ill,
                     input logic stall, input logic start, input logic done);
    @(posedge clk);
    #1;
    reset = rst; valid_i = v; funct7_i = f7; ALU_Op_i = aop; funct3_i = f3;
    if (chk) begin
      exp_q.push_back({op, ill, stall, start, done});
      name_q.push_back(nm);
    end
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the next expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e, a;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {ALU_Operation_o, Illegal_o, Stall_o, Mdu_Start_o, Done_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got op=%0d ill=%b stall=%b start=%b done=%b, want op=%0d ill=%b stall=%b start=%b done=%b",
                 nm, a[8:4], a[3], a[2], a[1], a[0], e[8:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_i = 1'b0; funct7_i = 7'h00; ALU_Op_i = 3'b000; funct3_i = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "rst_idle",      0, 0, 0, 0, 0);
    cyc(1, 0, 7'h20, 3'b000, 3'b000, 1, "r_sub",         1, 0, 0, 0, 0);
    cyc(1, 0, 7'h20, 3'b000, 3'b101, 1, "r_sra",         8, 0, 0, 0, 0);
    cyc(1, 0, 7'h20, 3'b001, 3'b101, 1, "i_srai",        8, 0, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b011, 3'b110, 1, "br_sltu",      10, 0, 0, 0, 0);
    cyc(1, 0, 7'h20, 3'b001, 3'b001, 1, "i_slli_bad",    0, 1, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b111, 1, "r_and",         2, 0, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b001, 1, "r_sll",         7, 0, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b001, 3'b101, 1, "i_srli",        6, 0, 0, 0, 0);
    cyc(1, 0, 7'h7f, 3'b001, 3'b010, 1, "i_slti_f7ign",  9, 0, 0, 0, 0);
    cyc(1, 0, 7'h55, 3'b010, 3'b111, 1, "ldst_add",      0, 0, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b100, 3'b000, 1, "lui",           5, 0, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b011, 3'b011, 1, "br_bad",        0, 1, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b011, 3'b101, 1, "br_slt",        9, 0, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b101, 3'b000, 1, "aluop_bad",     0, 1, 0, 0, 0);
    cyc(1, 1, 7'h20, 3'b000, 3'b010, 1, "r_f7alt_bad",   0, 1, 0, 0, 0);
    cyc(1, 1, 7'h02, 3'b000, 3'b000, 1, "r_f7_bad",      0, 1, 0, 0, 0);
    cyc(1, 1, 7'h00, 3'b000, 3'b011, 1, "valid_sltu",   10, 0, 0, 0, 0);

`ifdef ALU_CTRL_MEXT_EN
    // MUL with latency 2, then MULHU accepted in the first IDLE cycle after Done_o.
    cyc(1, 1, 7'h01, 3'b000, 3'b000, 1, "mul_c0",  11, 0, 1, 1, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "mul_c1",  11, 0, 1, 0, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "mul_c2",  11, 0, 0, 0, 1);
    cyc(1, 1, 7'h01, 3'b000, 3'b011, 1, "mulhu_c0", 14, 0, 1, 1, 0);
    cyc(1, 1, 7'h00, 3'b000, 3'b100, 1, "mulhu_c1", 14, 0, 1, 0, 0);
    cyc(1, 1, 7'h00, 3'b000, 3'b100, 1, "mulhu_c2", 14, 0, 0, 0, 1);
    cyc(1, 1, 7'h00, 3'b000, 3'b100, 1, "post_mul",  4, 0, 0, 0, 0);

    // DIVU, latency 32; inputs switch to ADD from cycle 5 and must be ignored.
    cyc(1, 1, 7'h01, 3'b000, 3'b101, 1, "divu_c0", 16, 0, 1, 1, 0);
    for (int i = 1; i < 32; i++) begin
      if (i < 5) cyc(1, 1, 7'h01, 3'b000, 3'b101, 1, "divu_busy", 16, 0, 1, 0, 0);
      else       cyc(1, 1, 7'h00, 3'b000, 3'b000, 1, "divu_busy", 16, 0, 1, 0, 0);
    end
    cyc(1, 1, 7'h00, 3'b000, 3'b000, 1, "divu_done", 16, 0, 0, 0, 1);
    cyc(1, 1, 7'h00, 3'b000, 3'b000, 1, "post_div",   0, 0, 0, 0, 0);

    // DIV abandoned by reset at cycle 10.
    cyc(1, 1, 7'h01, 3'b000, 3'b100, 1, "div_c0", 15, 0, 1, 1, 0);
    for (int i = 1; i < 10; i++)
      cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "div_busy", 15, 0, 1, 0, 0);
    cyc(0, 0, 7'h00, 3'b000, 3'b000, 1, "div_rst_c10", 15, 0, 1, 0, 0);
    cyc(1, 0, 7'h20, 3'b000, 3'b000, 1, "div_rst_c11",  1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++)
      cyc(1, 0, 7'h20, 3'b000, 3'b000, 1, "no_done",    1, 0, 0, 0, 0);
    cyc(1, 1, 7'h01, 3'b000, 3'b001, 1, "mulh_after_rst", 12, 0, 1, 1, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "mulh_c1",        12, 0, 1, 0, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "mulh_c2",        12, 0, 0, 0, 1);
    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "mulh_post",       0, 0, 0, 0, 0);
`else
    cyc(1, 1, 7'h01, 3'b000, 3'b000, 1, "mul_illegal",  0, 1, 0, 0, 0);
    cyc(1, 1, 7'h01, 3'b000, 3'b101, 1, "divu_illegal", 0, 1, 0, 0, 0);
    cyc(1, 0, 7'h00, 3'b000, 3'b000, 1, "mul_after",    0, 0, 0, 0, 0);
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
